// File: rtl/biquad_coef_bank.sv
// biquad_coef_bank: double-buffered coefficient store for a direct-form biquad.
//
// A host writes coefficients into a shadow set, then requests a commit. The shadow
// set is checked against the second-order stability triangle; if it passes, the live
// set is reloaded on the next sample boundary so that the filter never sees a mix of
// old and new coefficients. An optional flush holds the filter state clear for
// FLUSH_CYCLES cycles after the reload.
//
// Ports:
//   clk            single clock, rising edge
//   reset          synchronous, active-high
//   wr_en          shadow register write strobe (ignored while busy)
//   wr_addr        0=b0 1=b1 2=b2 3=a1 4=a2, 5..7 ignored
//   wr_data        signed coefficient, 1.0 = 2**(COEF_WIDTH-3)
//   commit         request shadow -> live transfer (accepted only when idle)
//   flush_en       sampled with commit; pulse filter_clear after the reload
//   sample_strobe  downstream in_valid; the reload happens on a strobe cycle
//   b0..a2         live coefficients
//   filter_clear   high while flushing the downstream filter state
//   busy           high whenever an update is in progress
//   done           one-cycle pulse when an update has completed
//   cfg_err        sticky; last commit was rejected as unstable
module biquad_coef_bank #(
    parameter int unsigned COEF_WIDTH   = 16,
    parameter int unsigned FLUSH_CYCLES = 4,
    parameter int          B0_INIT      = 2**13,
    parameter int          B1_INIT      = 0,
    parameter int          B2_INIT      = 0,
    parameter int          A1_INIT      = 0,
    parameter int          A2_INIT      = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [2:0]            wr_addr,
    input  logic [COEF_WIDTH-1:0] wr_data,
    input  logic                  commit,
    input  logic                  flush_en,
    input  logic                  sample_strobe,
    output logic [COEF_WIDTH-1:0] b0,
    output logic [COEF_WIDTH-1:0] b1,
    output logic [COEF_WIDTH-1:0] b2,
    output logic [COEF_WIDTH-1:0] a1,
    output logic [COEF_WIDTH-1:0] a2,
    output logic                  filter_clear,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);

    localparam int unsigned EW = COEF_WIDTH + 2;
    localparam logic signed [EW-1:0] ONE_EXT = EW'(2**(COEF_WIDTH-3));

    localparam logic [COEF_WIDTH-1:0] B0_RST = COEF_WIDTH'(B0_INIT);
    localparam logic [COEF_WIDTH-1:0] B1_RST = COEF_WIDTH'(B1_INIT);
    localparam logic [COEF_WIDTH-1:0] B2_RST = COEF_WIDTH'(B2_INIT);
    localparam logic [COEF_WIDTH-1:0] A1_RST = COEF_WIDTH'(A1_INIT);
    localparam logic [COEF_WIDTH-1:0] A2_RST = COEF_WIDTH'(A2_INIT);

    localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StWait,
        StFlush
    } state_e;

    state_e state_q, state_d;

    logic [COEF_WIDTH-1:0] sh_b0_q, sh_b0_d, sh_b1_q, sh_b1_d, sh_b2_q, sh_b2_d;
    logic [COEF_WIDTH-1:0] sh_a1_q, sh_a1_d, sh_a2_q, sh_a2_d;
    logic [COEF_WIDTH-1:0] b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
    logic [COEF_WIDTH-1:0] a1_q, a1_d, a2_q, a2_d;
    logic                  flush_q, flush_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  cfg_err_q, cfg_err_d;

    // Stability triangle: |a2| < 1 and |a1| < 1 + a2. Two guard bits make the
    // absolute value of the most negative code and the sum 1 + a2 overflow-free.
    logic signed [EW-1:0] a1_ext, a2_ext, a1_abs, a2_abs, a1_bound;
    logic                 stable;

    always_comb begin
        a1_ext   = {{2{sh_a1_q[COEF_WIDTH-1]}}, sh_a1_q};
        a2_ext   = {{2{sh_a2_q[COEF_WIDTH-1]}}, sh_a2_q};
        a1_abs   = a1_ext[EW-1] ? -a1_ext : a1_ext;
        a2_abs   = a2_ext[EW-1] ? -a2_ext : a2_ext;
        a1_bound = ONE_EXT + a2_ext;
        stable   = (a2_abs < ONE_EXT) && (a1_abs < a1_bound);
    end

    always_comb begin
        state_d   = state_q;
        sh_b0_d   = sh_b0_q;
        sh_b1_d   = sh_b1_q;
        sh_b2_d   = sh_b2_q;
        sh_a1_d   = sh_a1_q;
        sh_a2_d   = sh_a2_q;
        b0_d      = b0_q;
        b1_d      = b1_q;
        b2_d      = b2_q;
        a1_d      = a1_q;
        a2_d      = a2_q;
        flush_d   = flush_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        cfg_err_d = cfg_err_q;

        // Shadow writes only land while idle, so a pending update sees a frozen set.
        if (wr_en && (state_q == StIdle)) begin
            case (wr_addr)
                3'd0:    sh_b0_d = wr_data;
                3'd1:    sh_b1_d = wr_data;
                3'd2:    sh_b2_d = wr_data;
                3'd3:    sh_a1_d = wr_data;
                3'd4:    sh_a2_d = wr_data;
                default: ;
            endcase
        end

        unique case (state_q)
            StIdle: begin
                if (commit) begin
                    flush_d   = flush_en;
                    cfg_err_d = 1'b0;
                    state_d   = StCheck;
                end
            end
            StCheck: begin
                if (stable) begin
                    state_d = StWait;
                end else begin
                    cfg_err_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            StWait: begin
                if (sample_strobe) begin
                    b0_d = sh_b0_q;
                    b1_d = sh_b1_q;
                    b2_d = sh_b2_q;
                    a1_d = sh_a1_q;
                    a2_d = sh_a2_q;
                    if (flush_q) begin
                        cnt_d   = FLUSH_LAST;
                        state_d = StFlush;
                    end else begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StFlush: begin
                if (cnt_q == 8'd0) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            sh_b0_q   <= B0_RST;
            sh_b1_q   <= B1_RST;
            sh_b2_q   <= B2_RST;
            sh_a1_q   <= A1_RST;
            sh_a2_q   <= A2_RST;
            b0_q      <= B0_RST;
            b1_q      <= B1_RST;
            b2_q      <= B2_RST;
            a1_q      <= A1_RST;
            a2_q      <= A2_RST;
            flush_q   <= 1'b0;
            cnt_q     <= 8'd0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_b0_q   <= sh_b0_d;
            sh_b1_q   <= sh_b1_d;
            sh_b2_q   <= sh_b2_d;
            sh_a1_q   <= sh_a1_d;
            sh_a2_q   <= sh_a2_d;
            b0_q      <= b0_d;
            b1_q      <= b1_d;
            b2_q      <= b2_d;
            a1_q      <= a1_d;
            a2_q      <= a2_d;
            flush_q   <= flush_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign b0           = b0_q;
    assign b1           = b1_q;
    assign b2           = b2_q;
    assign a1           = a1_q;
    assign a2           = a2_q;
    assign filter_clear = (state_q == StFlush);
    assign busy         = (state_q != StIdle);
    assign done         = done_q;
    assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_biquad_coef_bank.sv
// Directed bench for biquad_coef_bank with hand-computed expectations
// (COEF_WIDTH=16, so 1.0 = 8192; FLUSH_CYCLES=4).
module tb_biquad_coef_bank;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         wr_en;
    logic [2:0]   wr_addr;
    logic [W-1:0] wr_data;
    logic         commit;
    logic         flush_en;
    logic         sample_strobe;
    logic [W-1:0] b0, b1, b2, a1, a2;
    logic         filter_clear, busy, done, cfg_err;

    int checks = 0;
    int errors = 0;

    biquad_coef_bank #(
        .COEF_WIDTH   (W),
        .FLUSH_CYCLES (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .commit        (commit),
        .flush_en      (flush_en),
        .sample_strobe (sample_strobe),
        .b0            (b0),
        .b1            (b1),
        .b2            (b2),
        .a1            (a1),
        .a2            (a2),
        .filter_clear  (filter_clear),
        .busy          (busy),
        .done          (done),
        .cfg_err       (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input int addr, input int data);
        wr_en   = 1'b1;
        wr_addr = 3'(addr);
        wr_data = W'(data);
        tick();
        wr_en   = 1'b0;
    endtask

    // Leaves the bench at cycle T+1 of the commit.
    task automatic do_commit(input logic fl);
        commit   = 1'b1;
        flush_en = fl;
        tick();
        commit   = 1'b0;
        flush_en = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        wr_en         = 1'b1;
        wr_addr       = 3'd0;
        wr_data       = 16'd5;
        commit        = 1'b1;
        flush_en      = 1'b0;
        sample_strobe = 1'b1;
        tick();
        tick();
        reset  = 1'b0;
        wr_en  = 1'b0;
        commit = 1'b0;

        // Reset state
        check("rst_b0", $signed(b0), 8192);
        check("rst_b1", $signed(b1), 0);
        check("rst_b2", $signed(b2), 0);
        check("rst_a1", $signed(a1), 0);
        check("rst_a2", $signed(a2), 0);
        check("rst_busy", busy, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_fclr", filter_clear, 0);
        check("rst_done", done, 0);

        // Plain update, no flush
        write(1, 2048);
        write(2, 2048);
        write(3, 4096);
        write(4, 4096);
        do_commit(1'b0);
        check("upd_t1_busy", busy, 1);
        check("upd_t1_done", done, 0);
        tick();
        check("upd_t2_b1_old", $signed(b1), 0);
        check("upd_t2_fclr", filter_clear, 0);
        tick();
        check("upd_t3_b1", $signed(b1), 2048);
        check("upd_t3_b2", $signed(b2), 2048);
        check("upd_t3_a1", $signed(a1), 4096);
        check("upd_t3_a2", $signed(a2), 4096);
        check("upd_t3_done", done, 1);
        check("upd_t3_busy", busy, 0);
        check("upd_t3_fclr", filter_clear, 0);
        tick();
        check("upd_t4_done", done, 0);

        // Unstable: |a2| = 1.0
        write(4, 8192);
        do_commit(1'b0);
        check("bad_t1_cfg_err", cfg_err, 0);
        tick();
        check("bad_t2_cfg_err", cfg_err, 1);
        check("bad_t2_busy", busy, 0);
        check("bad_t2_done", done, 0);
        check("bad_t2_a2", $signed(a2), 4096);
        tick();
        check("bad_t3_done", done, 0);
        check("bad_t3_a2", $signed(a2), 4096);

        // Passing commit clears cfg_err
        write(4, 0);
        do_commit(1'b0);
        check("ok_t1_cfg_err", cfg_err, 0);
        tick();
        tick();
        check("ok_t3_a2", $signed(a2), 0);
        check("ok_t3_done", done, 1);

        // Most negative a1 (|a1| = 4.0) must fail
        write(3, -32768);
        do_commit(1'b0);
        tick();
        check("neg_a1_cfg_err", cfg_err, 1);
        check("neg_a1_live", $signed(a1), 4096);

        // a1 = 1.0 - 1 LSB with a2 = 0 is just inside the triangle
        write(3, 8191);
        do_commit(1'b0);
        tick();
        check("edge_a1_cfg_err", cfg_err, 0);
        check("edge_a1_busy", busy, 1);
        tick();
        check("edge_a1_live", $signed(a1), 8191);

        // WAIT holds while sample_strobe stays low
        sample_strobe = 1'b0;
        write(3, 1000);
        do_commit(1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 0 || i == 19) begin
                check("wait_busy", busy, 1);
                check("wait_a1", $signed(a1), 8191);
            end
        end
        write(3, 555);  // dropped: busy
        check("wait_busy_after_wr", busy, 1);
        sample_strobe = 1'b1;
        tick();
        check("wait_rel_a1", $signed(a1), 1000);
        check("wait_rel_done", done, 1);

        // Flush update; re-commits shadow, so a1 stays 1000 if the WAIT write was dropped
        do_commit(1'b1);
        check("fl_t1_fclr", filter_clear, 0);
        tick();
        check("fl_t2_fclr", filter_clear, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("fl_active_fclr", filter_clear, 1);
            check("fl_active_done", done, 0);
            if (k == 0) check("fl_t3_a1", $signed(a1), 1000);
        end
        tick();
        check("fl_t7_fclr", filter_clear, 0);
        check("fl_t7_done", done, 1);
        check("fl_t7_busy", busy, 0);

        // Reset in the middle of FLUSH
        do_commit(1'b1);
        tick();
        tick();
        tick();
        check("flrst_pre_fclr", filter_clear, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("flrst_fclr", filter_clear, 0);
        check("flrst_busy", busy, 0);
        check("flrst_b0", $signed(b0), 8192);
        check("flrst_b1", $signed(b1), 0);
        check("flrst_a1", $signed(a1), 0);
        check("flrst_done", done, 0);

        // Write and commit in the same cycle
        wr_en    = 1'b1;
        wr_addr  = 3'd3;
        wr_data  = W'(-4096);
        commit   = 1'b1;
        flush_en = 1'b0;
        tick();
        wr_en  = 1'b0;
        commit = 1'b0;
        tick();
        check("same_t2_cfg_err", cfg_err, 0);
        tick();
        check("same_t3_a1", $signed(a1), -4096);
        check("same_t3_done", done, 1);

        // Write to an unused address changes nothing
        write(6, 1234);
        do_commit(1'b0);
        tick();
        tick();
        check("addr6_b0", $signed(b0), 8192);
        check("addr6_b1", $signed(b1), 0);
        check("addr6_b2", $signed(b2), 0);
        check("addr6_a1", $signed(a1), -4096);
        check("addr6_a2", $signed(a2), 0);
        check("addr6_cfg_err", cfg_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
